// File: rtl/leading_one_expander_pkg.sv
// Shared constants, S1 payload type and position decode for the leading-one expander.
package leading_one_expander_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned LOC_W    = 6;
  localparam int unsigned MANT_MAX = 31;

  typedef struct packed {
    logic [LOC_W-1:0]    loc;
    logic [MANT_MAX-1:0] mant;
    logic                err;
  } s1_payload_t;

  // One-hot of bit L-1; all-zero for L = 0 and for out-of-range L.
  function automatic logic [WORD_W-1:0] loc_to_onehot(input logic [LOC_W-1:0] loc);
    logic [WORD_W-1:0] oh;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      oh[i] = (loc == LOC_W'(i + 1));
    end
    return oh;
  endfunction

  function automatic logic loc_is_err(input logic [LOC_W-1:0] loc);
    return loc > LOC_W'(WORD_W);
  endfunction

endpackage

// File: rtl/lo_place.sv
// Combinational placement of the leading one and the mantissa bits below it.
// Optional RECON_MIDPOINT_EN sets the bit just below the mantissa.
module lo_place
  import leading_one_expander_pkg::*;
#(
  parameter int unsigned MANT_W = 4
) (
  input  logic [WORD_W-1:0] onehot,
  input  logic [MANT_W-1:0] mantissa,
  output logic [WORD_W-1:0] word
);

  // Each mantissa bit k lands k+1 places below the leading one; bits shifted
  // past bit 0 fall off naturally.
  always_comb begin
    word = onehot;
    for (int k = 0; k < MANT_W; k++) begin
      word = word | ({WORD_W{mantissa[MANT_W-1-k]}} & (onehot >> (k + 1)));
    end
`ifdef RECON_MIDPOINT_EN
    word = word | (onehot >> (MANT_W + 1));
`endif
  end

endmodule

// File: rtl/leading_one_expander.sv
// Two-stage valid/ready pipeline rebuilding a 32-bit word from a leading-one code.
// Build option: RECON_MIDPOINT_EN (midpoint reconstruction below the mantissa).
module leading_one_expander
  import leading_one_expander_pkg::*;
#(
  parameter int unsigned MANT_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LOC_W-1:0]  locationOfOne,
  input  logic [MANT_W-1:0] mantissa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_count
);

  logic              s1_valid;
  s1_payload_t       s1_q, s1_d;
  logic [WORD_W-1:0] s1_onehot_q, s1_onehot_d;
  logic [WORD_W-1:0] placed;
  logic              s2_adv;
  logic              in_fire;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    s1_d                   = '0;
    s1_d.loc               = locationOfOne;
    s1_d.mant[MANT_W-1:0]  = mantissa;
    s1_d.err               = loc_is_err(locationOfOne);
    s1_onehot_d            = loc_to_onehot(locationOfOne);
  end

  // S1: code plus decoded position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      s1_onehot_q <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q        <= s1_d;
        s1_onehot_q <= s1_onehot_d;
      end
    end
  end

  lo_place #(
    .MANT_W (MANT_W)
  ) u_lo_place (
    .onehot   (s1_onehot_q),
    .mantissa (s1_q.mant[MANT_W-1:0]),
    .word     (placed)
  );

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_word <= placed;
        out_err  <= s1_q.err;
      end
    end
  end

  // Counted at acceptance, so stalled or reset-discarded words are still counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (in_fire && s1_d.err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

  // The raw location and upper mantissa bits travel with the payload but the
  // word is built from the registered one-hot.
  logic unused_s1;
  assign unused_s1 = ^{s1_q.loc, s1_q.mant};

endmodule

// File: tb/tb_leading_one_expander.sv
// Directed self-checking bench for leading_one_expander (MANT_W = 4, CNT_W = 4).
module tb_leading_one_expander;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  locationOfOne;
  logic [3:0]  mantissa;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_err;
  logic [3:0]  err_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_cnt      = 0;

`ifdef RECON_MIDPOINT_EN
  localparam bit Mid = 1'b1;
`else
  localparam bit Mid = 1'b0;
`endif

  leading_one_expander #(
    .MANT_W (4),
    .CNT_W  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .locationOfOne (locationOfOne),
    .mantissa      (mantissa),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_word      (out_word),
    .out_err       (out_err),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; locationOfOne = '0; mantissa = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    tests_run++;
    if (err_count !== 4'd0) begin
      tests_failed++; $display("FAIL reset_err_count: got %0d, required 0", err_count);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    tests_run++;
    if (out_word !== 32'h0 || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_word: got %h/%b, required 00000000/0", out_word, out_err);
    end
  endtask

  task automatic test_placement();
    logic [5:0]  locs [9] = '{6'd32, 6'd3, 6'd0, 6'd40, 6'd8, 6'd16, 6'd5, 6'd6, 6'd33};
    logic [3:0]  mants[9] = '{4'b1010, 4'b1011, 4'b1111, 4'b1111, 4'b0001, 4'b1111, 4'b1100,
                              4'b0110, 4'b0000};
    logic [31:0] plain[9] = '{32'hD000_0000, 32'h6, 32'h0, 32'h0, 32'h88, 32'hF800, 32'h1C,
                              32'h2C, 32'h0};
    logic [31:0] midp [9] = '{32'hD400_0000, 32'h6, 32'h0, 32'h0, 32'h8C, 32'hFC00, 32'h1C,
                              32'h2D, 32'h0};
    logic        errs [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_word;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1; locationOfOne = locs[i]; mantissa = mants[i];
      if (errs[i]) exp_cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      exp_word = Mid ? midp[i] : plain[i];
      tests_run++;
      if (out_valid !== 1'b1) begin
        tests_failed++; $display("FAIL place_valid L=%0d: got %b, required 1", locs[i], out_valid);
      end
      tests_run++;
      if (out_word !== exp_word) begin
        tests_failed++;
        $display("FAIL place_word L=%0d: got %h, required %h", locs[i], out_word, exp_word);
      end
      tests_run++;
      if (out_err !== errs[i]) begin
        tests_failed++;
        $display("FAIL place_err L=%0d: got %b, required %b", locs[i], out_err, errs[i]);
      end
      tests_run++;
      if (err_count !== 4'(exp_cnt)) begin
        tests_failed++;
        $display("FAIL place_cnt L=%0d: got %0d, required %0d", locs[i], err_count, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  locs [4] = '{6'd7, 6'd2, 6'd31, 6'd1};
    logic [3:0]  mants[4] = '{4'b1001, 4'b1000, 4'b0111, 4'b1111};
    logic [31:0] plain[4] = '{32'h64, 32'h3, 32'h5C00_0000, 32'h1};
    logic [31:0] midp [4] = '{32'h66, 32'h3, 32'h5E00_0000, 32'h1};
    int nrecv = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== (cyc >= 2 && cyc <= 5)) begin
        tests_failed++; $display("FAIL b2b_valid cyc=%0d: got %b", cyc, out_valid);
      end
      if (out_valid) begin
        tests_run++;
        if (nrecv >= 4) begin
          tests_failed++; $display("FAIL b2b_extra: got word %h, required none", out_word);
        end else if (out_word !== (Mid ? midp[nrecv] : plain[nrecv])) begin
          tests_failed++;
          $display("FAIL b2b_word %0d: got %h, required %h", nrecv, out_word,
                   Mid ? midp[nrecv] : plain[nrecv]);
        end
        nrecv++;
      end
      if (cyc < 4) begin
        in_valid = 1'b1; locationOfOne = locs[cyc]; mantissa = mants[cyc];
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
          tests_failed++; $display("FAIL b2b_in_ready cyc=%0d: got %b, required 1", cyc, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    tests_run++;
    if (nrecv != 4) begin
      tests_failed++; $display("FAIL b2b_count: got %0d words, required 4", nrecv);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic [31:0] exp_w[3] = '{32'h1, 32'h2, 32'h4};
    logic drop = 1'b0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; locationOfOne = 6'd1; mantissa = 4'b0000;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_ready1: got %b, required 1", in_ready);
    end
    @(negedge clk);
    locationOfOne = 6'd2;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_ready2: got %b, required 1", in_ready);
    end
    @(negedge clk);
    locationOfOne = 6'd3;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_ready3: got %b, required 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 32'h1) begin
        tests_failed++;
        $display("FAIL bp_hold %0d: got ready=%b valid=%b word=%h, required 0/1/00000001",
                 i, in_ready, out_valid, out_word);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (drop) in_valid = 1'b0;
      #1;
      if (out_valid) got.push_back(out_word);
      drop = in_valid && in_ready;
    end
    tests_run++;
    if (got.size() != 3) begin
      tests_failed++; $display("FAIL bp_count: got %0d words, required 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp_w[i]) begin
        tests_failed++; $display("FAIL bp_order %0d: got %h, required %h", i, got[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tests_run++;
      if (err_count !== 4'(exp_cnt)) begin
        tests_failed++; $display("FAIL sat_cnt %0d: got %0d, required %0d", i, err_count, exp_cnt);
      end
      in_valid = 1'b1;
      locationOfOne = (i == 15) ? 6'd63 : 6'(33 + i);
      mantissa = 4'(i);
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (err_count !== 4'hF) begin
      tests_failed++; $display("FAIL sat_final: got %0d, required 15", err_count);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; locationOfOne = 6'd5; mantissa = 4'b0000;
    @(negedge clk);
    locationOfOne = 6'd40;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_word !== 32'h10) begin
      tests_failed++;
      $display("FAIL ar_pre: got valid=%b word=%h, required 1/00000010", out_valid, out_word);
    end
    #2 rst = 1'b1;
    #1;
    exp_cnt = 0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL ar_valid: got %b, required 0", out_valid);
    end
    tests_run++;
    if (out_word !== 32'h0 || out_err !== 1'b0 || err_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL ar_state: got word=%h err=%b cnt=%0d, required 0/0/0",
               out_word, out_err, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL ar_in_ready: got %b, required 1", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL ar_stale %0d: got valid word %h, required none", i, out_word);
      end
    end
    in_valid = 1'b1; locationOfOne = 6'd4; mantissa = 4'b0001;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_word !== 32'h8 || err_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL ar_recover: got valid=%b word=%h cnt=%0d, required 1/00000008/0",
               out_valid, out_word, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_placement();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/leading_one_expander.md
LEADING_ONE_EXPANDER -- requirements
Module: leading_one_expander

Interface
REQ-001 SHALL have parameter MANT_W, default 4, number of mantissa bits stored below the leading one (1..31).
REQ-002 SHALL have parameter CNT_W, default 16, width of the error counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, the input code is valid.
REQ-006 SHALL have port in_ready, output, 1, the block accepts the input code this cycle.
REQ-007 SHALL have port locationOfOne, input, 6, 1-based position of the leading one (0 = zero word).
REQ-008 SHALL have port mantissa, input, MANT_W, the bits directly below the leading one, MSB first.
REQ-009 SHALL have port out_valid, output, 1, out_word/out_err are valid.
REQ-010 SHALL have port out_ready, input, 1, the downstream accepts the output.
REQ-011 SHALL have port out_word, output, 32, the reconstructed word.
REQ-012 SHALL have port out_err, output, 1, locationOfOne > 32 for this word.
REQ-013 SHALL have port err_count, output, CNT_W, saturating count of accepted codes with locationOfOne > 32.

Function
REQ-014 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-015 SHALL be a 2-stage pipeline: S1 registers the code and the decoded one-hot position; S2 registers out_word/out_err.
REQ-016 SHALL present the result 2 cycles after acceptance with no backpressure; throughput 1 word/cycle.
REQ-017 SHALL set in_ready = !s1_valid || s2_adv, where s2_adv = !out_valid || out_ready; in_ready is independent of in_valid.
REQ-018 SHALL hold out_word/out_err stable while out_valid && !out_ready; words SHALL exit in acceptance order, none lost or duplicated.
REQ-019 L = 0: out_word SHALL be 32'h0, out_err = 0.
REQ-020 L in 1..32: bit L-1 SHALL be 1; mantissa[MANT_W-1-k] SHALL go to bit L-2-k for k = 0..MANT_W-1; positions below bit 0 SHALL be dropped; all other bits 0.
REQ-021 L in 33..63: out_word SHALL be 32'h0, out_err = 1.
REQ-022 err_count SHALL increment by 1 on each accepted code with L > 32, counting at acceptance, and SHALL saturate at all-ones.
REQ-023 Mantissa SHALL be ignored when L = 0 or L > 32.

Reset
REQ-024 rst SHALL clear s1_valid, out_valid, out_word, out_err and err_count to 0 immediately, independent of clk.
REQ-025 Words in flight when rst asserts SHALL be discarded; in_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-026 With RECON_MIDPOINT_EN defined, bit L-2-MANT_W SHALL be set to 1 when L in 1..32 and L-2-MANT_W >= 0 (midpoint reconstruction); otherwise SHALL be 0.
REQ-027 Without RECON_MIDPOINT_EN, all bits below the mantissa SHALL be 0; no other behaviour differs.

Structure
REQ-028 A shared package SHALL hold the word width constant (32), the location width (6), and a struct for the S1 payload (location, mantissa, err flag).
REQ-029 The position-plus-mantissa placement SHALL be a sub-module lo_place (combinational, parameterised by MANT_W), instantiated between S1 and S2.

Verification (MANT_W = 4)
REQ-030 L=32, mantissa=4'b1010, out_ready=1 -> out_word=32'hD000_0000 two cycles later (32'hD400_0000 with RECON_MIDPOINT_EN).
REQ-031 L=3, mantissa=4'b1011 -> out_word=32'h0000_0006, midpoint bit absent in both builds.
REQ-032 L=0, then L=40 -> out_word=0/out_err=0, then out_word=0/out_err=1; err_count 0 -> 1.
REQ-033 Inputs L=1,2,3 on back-to-back cycles, out_ready=0 for 4 cycles -> in_ready=0 from the cycle after the 2nd acceptance; after out_ready=1, outputs are 1,2,4 in order.
REQ-034 Set err_count to the maximum, then apply L=63 -> err_count stays all-ones.
REQ-035 Assert rst asynchronously with 2 words in flight -> out_valid=0 immediately, no stale word after release, err_count=0.
